trigger_pulse_gen: RTL and testbench

TRIGGER_PULSE_GEN -- requirements
Module: trigger_pulse_gen

---
 rtl/trigger_pulse_gen.sv | 162 ++++++++++++++++
 tb/tb_trigger_pulse_gen.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_pulse_gen.sv
// Camera trigger sequencer: delays each accepted bitplane-ready pulse, issues a
// fixed-width trigger, enforces a holdoff, and tracks plane index and status.
module trigger_pulse_gen #(
    parameter int unsigned DELAY_CYCLES   = 3,
    parameter int unsigned PULSE_CYCLES   = 4,
    parameter int unsigned HOLDOFF_CYCLES = 2,
    parameter int unsigned N_BIT_PLANES   = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send,
    input  logic        enable,
    input  logic        clr_status,
    output logic        trigger,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] trig_count,
    output logic [7:0]  plane_idx,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_PULSE,
        S_HOLDOFF
    } state_t;

    localparam logic [15:0] DLY_LOAD   = (DELAY_CYCLES   == 0) ? 16'd0 : 16'(DELAY_CYCLES - 1);
    localparam logic [15:0] PLS_LOAD   = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] HLD_LOAD   = (HOLDOFF_CYCLES == 0) ? 16'd0 : 16'(HOLDOFF_CYCLES - 1);
    localparam logic [7:0]  LAST_PLANE = 8'(N_BIT_PLANES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        trigger_q, trigger_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;
    logic [15:0] trig_count_q, trig_count_d;
    logic [7:0]  plane_idx_q, plane_idx_d;
    logic        frame_done_q, frame_done_d;

    logic send_ok;
    logic pulse_entry;
    logic pulse_exit;

    assign send_ok = send & enable;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pulse_entry = 1'b0;
        pulse_exit  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (send_ok) begin
                    if (DELAY_CYCLES == 0) begin
                        state_d     = S_PULSE;
                        cnt_d       = PLS_LOAD;
                        pulse_entry = 1'b1;
                    end else begin
                        state_d = S_DELAY;
                        cnt_d   = DLY_LOAD;
                    end
                end
            end
            S_DELAY: begin
                if (cnt_q == 16'd0) begin
                    state_d     = S_PULSE;
                    cnt_d       = PLS_LOAD;
                    pulse_entry = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_PULSE: begin
                if (cnt_q == 16'd0) begin
                    pulse_exit = 1'b1;
                    if (HOLDOFF_CYCLES == 0) begin
                        state_d = S_IDLE;
                        cnt_d   = 16'd0;
                    end else begin
                        state_d = S_HOLDOFF;
                        cnt_d   = HLD_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_HOLDOFF: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        trigger_d = (state_d == S_PULSE);
        busy_d    = (state_d != S_IDLE);

        // A dropped send wins over a simultaneous clear.
        if (send_ok && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end else if (clr_status) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        trig_count_d = (clr_status ? 16'd0 : trig_count_q) + {15'd0, pulse_entry};

        plane_idx_d  = plane_idx_q;
        frame_done_d = 1'b0;
        if (pulse_exit) begin
            if (plane_idx_q == LAST_PLANE) begin
                plane_idx_d  = 8'd0;
                frame_done_d = 1'b1;
            end else begin
                plane_idx_d = plane_idx_q + 8'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 16'd0;
            trigger_q    <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            trig_count_q <= 16'd0;
            plane_idx_q  <= 8'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            trigger_q    <= trigger_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            trig_count_q <= trig_count_d;
            plane_idx_q  <= plane_idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign trigger    = trigger_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign trig_count = trig_count_q;
    assign plane_idx  = plane_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Directed bench for trigger_pulse_gen: default-parameter instance plus a
// zero-delay/zero-holdoff instance for back-to-back triggering.
module tb_trigger_pulse_gen;

    logic        clk = 1'b0;
    logic        rst, send, enable, clr_status;
    logic        trigger, busy, overrun, frame_done;
    logic [15:0] trig_count;
    logic [7:0]  plane_idx;

    logic        z_send, z_enable, z_clr;
    logic        z_trigger, z_busy, z_overrun, z_frame_done;
    logic [15:0] z_trig_count;
    logic [7:0]  z_plane_idx;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    trigger_pulse_gen u_dut (
        .clk        (clk),
        .rst        (rst),
        .send       (send),
        .enable     (enable),
        .clr_status (clr_status),
        .trigger    (trigger),
        .busy       (busy),
        .overrun    (overrun),
        .trig_count (trig_count),
        .plane_idx  (plane_idx),
        .frame_done (frame_done)
    );

    trigger_pulse_gen #(
        .DELAY_CYCLES   (0),
        .PULSE_CYCLES   (4),
        .HOLDOFF_CYCLES (0),
        .N_BIT_PLANES   (12)
    ) u_dut_z (
        .clk        (clk),
        .rst        (rst),
        .send       (z_send),
        .enable     (z_enable),
        .clr_status (z_clr),
        .trigger    (z_trigger),
        .busy       (z_busy),
        .overrun    (z_overrun),
        .trig_count (z_trig_count),
        .plane_idx  (z_plane_idx),
        .frame_done (z_frame_done)
    );

    // Inputs change and outputs are sampled on the falling edge; point i is the
    // falling edge just before rising edge i, edge 0 being the one that samples send.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; send = 1'b0; enable = 1'b1; clr_status = 1'b0;
        z_send = 1'b0; z_enable = 1'b1; z_clr = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; send = 1'b0; enable = 1'b1; clr_status = 1'b0;
        z_send = 1'b0; z_enable = 1'b1; z_clr = 1'b0;
        repeat (2) tick();
        vectors++;
        if ({trigger, busy, overrun, frame_done, trig_count, plane_idx} !== 28'd0) begin
            miscompares++;
            $display("FAIL reset_state: got trig=%b busy=%b ovr=%b fd=%b cnt=%0d idx=%0d, expected all 0",
                     trigger, busy, overrun, frame_done, trig_count, plane_idx);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic exp_trig, exp_busy;
        do_reset();
        for (int i = 0; i <= 12; i++) begin
            send = (i == 0);
            if (i >= 1) begin
                exp_trig = (i >= 4) && (i <= 7);
                exp_busy = (i <= 9);
                vectors++;
                if (trigger !== exp_trig) begin
                    miscompares++;
                    $display("FAIL single_trigger@%0d: got %b expected %b", i, trigger, exp_trig);
                end
                vectors++;
                if (busy !== exp_busy) begin
                    miscompares++;
                    $display("FAIL single_busy@%0d: got %b expected %b", i, busy, exp_busy);
                end
            end
            tick();
        end
        vectors++;
        if (trig_count !== 16'd1) begin
            miscompares++;
            $display("FAIL single_trig_count: got %0d expected 1", trig_count);
        end
        vectors++;
        if (plane_idx !== 8'd1) begin
            miscompares++;
            $display("FAIL single_plane_idx: got %0d expected 1", plane_idx);
        end
    endtask

    task automatic test_frame();
        logic exp_trig, exp_fd;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 20; i++) begin
                send = (i == 0);
                if (i >= 1) begin
                    exp_trig = (i >= 4) && (i <= 7);
                    exp_fd   = (k == 11) && (i == 8);
                    vectors++;
                    if (trigger !== exp_trig) begin
                        miscompares++;
                        $display("FAIL frame_trigger k=%0d @%0d: got %b expected %b", k, i, trigger, exp_trig);
                    end
                    vectors++;
                    if (frame_done !== exp_fd) begin
                        miscompares++;
                        $display("FAIL frame_done k=%0d @%0d: got %b expected %b", k, i, frame_done, exp_fd);
                    end
                end
                tick();
            end
            vectors++;
            if (plane_idx !== 8'((k + 1) % 12)) begin
                miscompares++;
                $display("FAIL frame_plane_idx k=%0d: got %0d expected %0d", k, plane_idx, (k + 1) % 12);
            end
        end
        vectors++;
        if (trig_count !== 16'd12) begin
            miscompares++;
            $display("FAIL frame_trig_count: got %0d expected 12", trig_count);
        end
    endtask

    task automatic test_overrun();
        logic exp_trig;
        do_reset();
        for (int i = 0; i <= 20; i++) begin
            send = (i == 0) || (i == 5);
            if (i >= 1) begin
                exp_trig = (i >= 4) && (i <= 7);
                vectors++;
                if (trigger !== exp_trig) begin
                    miscompares++;
                    $display("FAIL overrun_trigger@%0d: got %b expected %b", i, trigger, exp_trig);
                end
                vectors++;
                if (overrun !== (i >= 6)) begin
                    miscompares++;
                    $display("FAIL overrun_flag@%0d: got %b expected %b", i, overrun, (i >= 6));
                end
            end
            tick();
        end
        vectors++;
        if (trig_count !== 16'd1) begin
            miscompares++;
            $display("FAIL overrun_trig_count: got %0d expected 1", trig_count);
        end

        // Clear lands on the same edge as S_PULSE entry and as a dropped send.
        for (int i = 0; i <= 12; i++) begin
            send       = (i == 0) || (i == 3);
            clr_status = (i == 3);
            if (i == 3) begin
                vectors++;
                if (trig_count !== 16'd1) begin
                    miscompares++;
                    $display("FAIL collide_pre_count: got %0d expected 1", trig_count);
                end
            end
            if (i == 4) begin
                vectors++;
                if (overrun !== 1'b1) begin
                    miscompares++;
                    $display("FAIL collide_overrun: got %b expected 1", overrun);
                end
                vectors++;
                if (trig_count !== 16'd1) begin
                    miscompares++;
                    $display("FAIL collide_trig_count: got %0d expected 1", trig_count);
                end
                vectors++;
                if (trigger !== 1'b1) begin
                    miscompares++;
                    $display("FAIL collide_trigger: got %b expected 1", trigger);
                end
            end
            tick();
        end

        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_overrun: got %b expected 0", overrun);
        end
        vectors++;
        if (trig_count !== 16'd0) begin
            miscompares++;
            $display("FAIL clear_trig_count: got %0d expected 0", trig_count);
        end
        vectors++;
        if (plane_idx !== 8'd2) begin
            miscompares++;
            $display("FAIL clear_plane_idx: got %0d expected 2", plane_idx);
        end
    endtask

    task automatic test_enable();
        logic exp_trig;
        do_reset();
        for (int i = 0; i <= 12; i++) begin
            enable = (i != 0);
            send   = (i == 0);
            if (i >= 1) begin
                vectors++;
                if ({trigger, busy, overrun} !== 3'b000) begin
                    miscompares++;
                    $display("FAIL disabled_send@%0d: got trig=%b busy=%b ovr=%b expected 000",
                             i, trigger, busy, overrun);
                end
            end
            tick();
        end
        for (int i = 0; i <= 12; i++) begin
            send   = (i == 0) || (i == 3);
            enable = (i < 2);
            if (i >= 1) begin
                exp_trig = (i >= 4) && (i <= 7);
                vectors++;
                if (trigger !== exp_trig) begin
                    miscompares++;
                    $display("FAIL enable_drop_trigger@%0d: got %b expected %b", i, trigger, exp_trig);
                end
                vectors++;
                if (overrun !== 1'b0) begin
                    miscompares++;
                    $display("FAIL enable_drop_overrun@%0d: got %b expected 0", i, overrun);
                end
            end
            tick();
        end
        enable = 1'b1;
        vectors++;
        if (trig_count !== 16'd1) begin
            miscompares++;
            $display("FAIL enable_trig_count: got %0d expected 1", trig_count);
        end
    endtask

    task automatic test_reset_mid();
        logic exp_trig;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send = (i == 0);
            tick();
        end
        vectors++;
        if (trigger !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_pre_trigger: got %b expected 1", trigger);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({trigger, busy, overrun, frame_done, trig_count, plane_idx} !== 28'd0) begin
            miscompares++;
            $display("FAIL midreset_async: got trig=%b busy=%b ovr=%b fd=%b cnt=%0d idx=%0d, expected all 0",
                     trigger, busy, overrun, frame_done, trig_count, plane_idx);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            send = (i == 0);
            if (i >= 1) begin
                exp_trig = (i >= 4) && (i <= 7);
                vectors++;
                if (trigger !== exp_trig) begin
                    miscompares++;
                    $display("FAIL postreset_trigger@%0d: got %b expected %b", i, trigger, exp_trig);
                end
            end
            tick();
        end
        vectors++;
        if (trig_count !== 16'd1 || plane_idx !== 8'd1) begin
            miscompares++;
            $display("FAIL postreset_status: got cnt=%0d idx=%0d expected cnt=1 idx=1", trig_count, plane_idx);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_trig;
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            z_send = (i == 0) || (i == 5) || (i == 10);
            if (i >= 1) begin
                exp_trig = (i <= 14) && (((i - 1) % 5) != 4);
                vectors++;
                if (z_trigger !== exp_trig) begin
                    miscompares++;
                    $display("FAIL b2b_trigger@%0d: got %b expected %b", i, z_trigger, exp_trig);
                end
                vectors++;
                if (z_busy !== exp_trig) begin
                    miscompares++;
                    $display("FAIL b2b_busy@%0d: got %b expected %b", i, z_busy, exp_trig);
                end
                vectors++;
                if (z_frame_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_frame_done@%0d: got %b expected 0", i, z_frame_done);
                end
            end
            tick();
        end
        vectors++;
        if (z_overrun !== 1'b0 || z_trig_count !== 16'd3 || z_plane_idx !== 8'd3) begin
            miscompares++;
            $display("FAIL b2b_status: got ovr=%b cnt=%0d idx=%0d expected ovr=0 cnt=3 idx=3",
                     z_overrun, z_trig_count, z_plane_idx);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_frame();
        test_overrun();
        test_enable();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
